conv_bias_relu_new: RTL and testbench

CONV_BIAS_RELU_NEW -- requirements
Module: conv_bias_relu_new

---
 rtl/conv_bias_relu_new.sv | 199 +++++++++++++++++++
 tb/tb_conv_bias_relu_new.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_bias_relu_new.sv
// conv_bias_relu_new
// Adds a per-channel bias to the channel-interleaved accumulated convolution
// stream, saturates the result to DATA_WIDTH and optionally rectifies it.
//
// Biases are loaded first (LOAD state, one per valid_bias_in, channel 0 first).
// Once all CHANNEL_NUM_OUT biases are stored the block switches to RUN and
// processes one sample per cycle with a fixed 2-cycle latency.
//
// Optional feature macro: CONV_BIAS_RELU_EN
//   defined   -> negative saturated sums are replaced by 0 (ReLU)
//   undefined -> saturated sum passes through unmodified
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   synchronous, active-high reset
//   valid_bias_in in   bias_in qualifier
//   bias_in       in   bias for the next channel index
//   valid_in      in   pxl_in qualifier
//   pxl_in        in   accumulated conv sum, ch0..chN-1 per pixel, raster order
//   pxl_out       out  biased, saturated (optionally rectified) sample
//   valid_out     out  pxl_out qualifier
//   bias_ready    out  high once all biases are stored
//   frame_done    out  one-cycle pulse with the last valid_out of a frame

module conv_bias_relu_new #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned CHANNEL_NUM_OUT = 256,
    parameter int unsigned IMAGE_WIDTH     = 306,
    parameter int unsigned IMAGE_HEIGHT    = 306
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  bias_ready,
    output logic                  frame_done
);

    localparam int unsigned PIX_NUM = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned CH_W    = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int unsigned PIX_W   = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
    localparam int unsigned SUM_W   = DATA_WIDTH + 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM_OUT - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_NUM - 1);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Stage-1 payload: registered sample, its bias and end-of-frame marker
    typedef struct packed {
        logic [DATA_WIDTH-1:0] pxl;
        logic [DATA_WIDTH-1:0] bias;
        logic                  last;
    } s1_t;

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [CH_W-1:0]       bias_ptr;
    logic [CH_W-1:0]       ch_cnt;
    logic [PIX_W-1:0]      pix_cnt;
    logic [DATA_WIDTH-1:0] bias_mem [CHANNEL_NUM_OUT];

    logic                  bias_wr_c;
    logic                  accept_c;
    logic                  ch_last_c;
    logic                  frame_last_c;

    s1_t                   s1;
    logic                  s1_valid;

    logic [SUM_W-1:0]      sum_c;
    logic [DATA_WIDTH-1:0] sat_c;
    logic [DATA_WIDTH-1:0] res_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt    = state;
        bias_wr_c    = 1'b0;
        accept_c     = 1'b0;
        ch_last_c    = (ch_cnt == CH_LAST);
        frame_last_c = ch_last_c && (pix_cnt == PIX_LAST);
        case (state)
            LOAD: begin
                // pixel samples arriving before the biases are complete are dropped
                if (valid_bias_in) begin
                    bias_wr_c = 1'b1;
                    if (bias_ptr == CH_LAST) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                // bias writes are ignored here so a stray bias cannot corrupt a frame
                accept_c = valid_in;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Bias storage; contents survive reset, a reload overwrites them
    always_ff @(posedge clk) begin
        if (bias_wr_c) begin
            bias_mem[bias_ptr] <= bias_in;
        end
    end

    // Bias write pointer and ready flag
    always_ff @(posedge clk) begin
        if (reset) begin
            bias_ptr   <= '0;
            bias_ready <= 1'b0;
        end else begin
            if (bias_wr_c) begin
                bias_ptr <= (bias_ptr == CH_LAST) ? '0 : bias_ptr + CH_W'(1);
            end
            bias_ready <= (state_nxt == RUN);
        end
    end

    // Channel / pixel position of the next accepted sample
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else if (accept_c) begin
            if (ch_last_c) begin
                ch_cnt  <= '0;
                pix_cnt <= frame_last_c ? '0 : pix_cnt + PIX_W'(1);
            end else begin
                ch_cnt  <= ch_cnt + CH_W'(1);
            end
        end
    end

    // Stage 1: bias read and sample register
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1.pxl  <= pxl_in;
                s1.bias <= bias_mem[ch_cnt];
                s1.last <= frame_last_c;
            end
        end
    end

    // Sign-extended add with saturation back to DATA_WIDTH
    always_comb begin
        sum_c = {s1.pxl[DATA_WIDTH-1], s1.pxl} + {s1.bias[DATA_WIDTH-1], s1.bias};
        sat_c = sum_c[DATA_WIDTH-1:0];
        // the two top bits disagree only when the true sum left the DATA_WIDTH range
        if (sum_c[SUM_W-1] != sum_c[SUM_W-2]) begin
            sat_c = sum_c[SUM_W-1] ? SAT_MIN : SAT_MAX;
        end
`ifdef CONV_BIAS_RELU_EN
        res_c = sat_c[DATA_WIDTH-1] ? '0 : sat_c;
`else
        res_c = sat_c;
`endif
    end

    // Stage 2: output register; pxl_out holds between valid samples
    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= s1_valid;
            frame_done <= s1_valid && s1.last;
            if (s1_valid) begin
                pxl_out <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_conv_bias_relu_new.sv
// Directed testbench for conv_bias_relu_new (DATA_WIDTH=16, 4 channels, 2x2 image).
// Expected outputs are hand-computed saturated sums; with CONV_BIAS_RELU_EN
// defined they are rectified before comparison.

module tb_conv_bias_relu_new;

    localparam int unsigned DW = 16;

    logic               clk;
    logic               reset;
    logic               valid_bias_in;
    logic [DW-1:0]      bias_in;
    logic               valid_in;
    logic [DW-1:0]      pxl_in;
    logic signed [DW-1:0] pxl_out;
    logic               valid_out;
    logic               bias_ready;
    logic               frame_done;

    int n_checks;
    int n_errors;
    int fd_cnt;

    // expected-output pipeline driven alongside the stimulus
    logic drv_v;
    int   drv_d;
    logic drv_f;
    logic e1_v, e1_f, e2_v, e2_f;
    int   e1_d, hold_d;
    logic mon_en;

    conv_bias_relu_new #(
        .DATA_WIDTH      (DW),
        .CHANNEL_NUM_OUT (4),
        .IMAGE_WIDTH     (2),
        .IMAGE_HEIGHT    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_bias_in (valid_bias_in),
        .bias_in       (bias_in),
        .valid_in      (valid_in),
        .pxl_in        (pxl_in),
        .pxl_out       (pxl_out),
        .valid_out     (valid_out),
        .bias_ready    (bias_ready),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int relu(input int v);
`ifdef CONV_BIAS_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            e1_v   <= 1'b0;
            e1_f   <= 1'b0;
            e1_d   <= 0;
            e2_v   <= 1'b0;
            e2_f   <= 1'b0;
            hold_d <= 0;
        end else begin
            e1_v <= drv_v;
            e1_d <= drv_d;
            e1_f <= drv_f;
            e2_v <= e1_v;
            e2_f <= e1_f;
            if (e1_v) hold_d <= e1_d;
        end
    end

    // every cycle: qualifier, held/updated data and frame pulse
    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_out", int'(valid_out), int'(e2_v));
            check("pxl_out", int'(pxl_out), hold_d);
            check("frame_done", int'(frame_done), int'(e2_v & e2_f));
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in      = 1'b0;
        valid_bias_in = 1'b0;
        drv_v         = 1'b0;
        drv_f         = 1'b0;
    endtask

    task automatic send(input int p, input int sum, input logic fd);
        valid_in = 1'b1;
        pxl_in   = DW'(p);
        drv_v    = 1'b1;
        drv_d    = relu(sum);
        drv_f    = fd;
        tick();
        idle();
    endtask

    task automatic send_drop(input int p);
        valid_in = 1'b1;
        pxl_in   = DW'(p);
        drv_v    = 1'b0;
        tick();
        idle();
    endtask

    task automatic load_bias(input int b, input logic with_pxl);
        valid_bias_in = 1'b1;
        bias_in       = DW'(b);
        valid_in      = with_pxl;
        pxl_in        = DW'(1234);
        drv_v         = 1'b0;
        tick();
        idle();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        fd_cnt   = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        bias_in  = '0;
        pxl_in   = '0;
        drv_d    = 0;
        idle();
        gap(2);
        check("rst_bias_ready", int'(bias_ready), 0);
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_pxl_out", int'(pxl_out), 0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // pixels in LOAD are dropped; load biases 10,-20,30,-40
        send_drop(77);
        load_bias(10, 1'b1);
        load_bias(-20, 1'b0);
        load_bias(30, 1'b1);
        check("bias_ready_before_last", int'(bias_ready), 0);
        load_bias(-40, 1'b0);
        check("bias_ready_after_load", int'(bias_ready), 1);

        // pixel 0: plain bias add
        fd_cnt = 0;
        send(100, 110, 1'b0);
        send(100, 80, 1'b0);
        send(100, 130, 1'b0);
        send(100, 60, 1'b0);

        // bias writes in RUN must be ignored
        valid_bias_in = 1'b1;
        bias_in       = DW'(999);
        gap(2);
        idle();

        // pixel 1: saturation and negative sums
        send(32767, 32767, 1'b0);
        send(-50, -70, 1'b0);
        send(32760, 32767, 1'b0);
        send(-32768, -32768, 1'b0);
        // pixel 2
        send(-32768, -32758, 1'b0);
        send(-32760, -32768, 1'b0);
        send(0, 30, 1'b0);
        send(40, 0, 1'b0);
        gap(1);
        // pixel 3: last sample of frame flags frame_done
        send(-10, 0, 1'b0);
        send(20, 0, 1'b0);
        send(-31, -1, 1'b0);
        send(1000, 960, 1'b1);
        // next frame starts again at channel 0
        send(5, 15, 1'b0);
        gap(2);
        check("frame_done_count", fd_cnt, 1);
        check("bias_ready_run", int'(bias_ready), 1);

        // 6 samples into the new frame, then reset with traffic in flight
        send(0, -20, 1'b0);
        send(0, 30, 1'b0);
        send(0, -40, 1'b0);
        send(0, 10, 1'b0);
        send(0, -20, 1'b0);
        reset    = 1'b1;
        valid_in = 1'b1;
        pxl_in   = DW'(500);
        tick();
        check("reset_bias_ready", int'(bias_ready), 0);
        check("reset_valid_out", int'(valid_out), 0);
        reset = 1'b0;
        idle();

        // outputs must not resume until a full reload
        send_drop(3);
        send_drop(4);
        load_bias(1, 1'b0);
        load_bias(2, 1'b0);
        load_bias(3, 1'b0);
        load_bias(4, 1'b0);
        check("reload_bias_ready", int'(bias_ready), 1);
        send(0, 1, 1'b0);
        send(0, 2, 1'b0);
        send(0, 3, 1'b0);
        send(0, 4, 1'b0);
        gap(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
